// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 16x-oversampling UART receiver with configurable character format.
//
// Receives one asynchronous serial character (start, 5..8 data bits LSB first,
// optional parity, one stop bit). Each finished character is offered to a
// receive FIFO, and one-cycle status pulses are raised alongside it.
//
// Ports
//   clock            single clock for all logic
//   reset            synchronous, active-high
//   baudRateX16tick  one-cycle enable pulse at 16x the bit rate
//   controlReg[6:0]  [1:0] data bits-5, [3] parity enable, [4] even parity,
//                    [5] stick parity; [2] and [6] unused
//   uartRxLine       asynchronous serial input, idle high
//   fifoFull         receive FIFO cannot accept a write
//   fifoWe           one-cycle FIFO write strobe
//   fifoData[7:0]    received character, first data bit in bit 0
//   parityError, frameError, breakDetected, overrunError
//                    one-cycle status pulses, aligned with the character
//   busy             high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       baudRateX16tick,
  input  logic [6:0] controlReg,
  input  logic       uartRxLine,
  input  logic       fifoFull,
  output logic       fifoWe,
  output logic [7:0] fifoData,
  output logic       parityError,
  output logic       frameError,
  output logic       breakDetected,
  output logic       overrunError,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        rx_prev_q, rx_prev_d;
  logic [2:0]  arm_q, arm_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  len_q, len_d;
  logic        par_en_q, par_en_d, even_q, even_d, stick_q, stick_d;
  logic        par_acc_q, par_acc_d, par_err_q, par_err_d, zero_q, zero_d;
  logic        we_q, we_d, perr_q, perr_d, ferr_q, ferr_d;
  logic        brk_q, brk_d, ovr_q, ovr_d;
  logic [7:0]  fdata_q, fdata_d;
  logic        rx_s, sample, exp_par;
  logic        unused_ctrl;

  assign rx_s        = sync2_q;
  assign unused_ctrl = ^{controlReg[6], controlReg[2]};

  // Mid-bit sample point in DATA/PARITY/STOP: the 16th tick, where the
  // counter wraps back to 0 on its own.
  assign sample = baudRateX16tick && (cnt_q == 4'd15);

  always_comb begin
    // NOTE: every _d takes a default first, so no path through the case
    // statement leaves a variable unassigned (which would infer a latch).
    state_d   = state_q;
    sync1_d   = uartRxLine;
    sync2_d   = sync1_q;
    rx_prev_d = rx_s;
    // Fills with ones after reset; edges count only once both rx_prev_q and
    // rx_s hold real line samples rather than the forced reset value.
    arm_d     = {arm_q[1:0], 1'b1};
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    even_d    = even_q;
    stick_d   = stick_q;
    par_acc_d = par_acc_q;
    par_err_d = par_err_q;
    zero_d    = zero_q;
    fdata_d   = fdata_q;
    we_d      = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;
    ovr_d     = 1'b0;
    exp_par   = stick_q ? ~even_q : ~(par_acc_q ^ even_q);

    case (state_q)
      S_IDLE: begin
        if (arm_q[2] && rx_prev_q && !rx_s) begin
          state_d = S_START;
          cnt_d   = 4'd0;
          bit_d   = 3'd0;
        end
      end

      S_START: begin
        if (baudRateX16tick) begin
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (rx_s) begin
              state_d = S_IDLE;            // false start
            end else begin
              // Format is frozen here for the whole character.
              state_d   = S_DATA;
              len_d     = controlReg[1:0];
              par_en_d  = controlReg[3];
              even_d    = controlReg[4];
              stick_d   = controlReg[5];
              data_d    = 8'h00;
              par_acc_d = 1'b0;
              par_err_d = 1'b0;
              zero_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (baudRateX16tick) cnt_d = cnt_q + 4'd1;
        if (sample) begin
          data_d[bit_q] = rx_s;
          par_acc_d     = par_acc_q ^ rx_s;
          zero_d        = zero_q & ~rx_s;
          bit_d         = bit_q + 3'd1;
          if (bit_q == ({1'b0, len_q} + 3'd4)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (baudRateX16tick) cnt_d = cnt_q + 4'd1;
        if (sample) begin
          par_err_d = rx_s ^ exp_par;
          zero_d    = zero_q & ~rx_s;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (baudRateX16tick) cnt_d = cnt_q + 4'd1;
        if (sample) begin
          state_d = rx_s ? S_IDLE : S_RECOVER;
          fdata_d = data_q;
          we_d    = !fifoFull;
          ovr_d   = fifoFull;
          ferr_d  = !rx_s;
          brk_d   = zero_q & !rx_s;
          perr_d  = par_err_q;
        end
      end

      S_RECOVER: begin
        // Ticks are ignored; a held-low break is reported only once.
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop sees the pre-edge values of the others.
    if (reset) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= 3'b000;
      cnt_q     <= 4'd0;
      bit_q     <= 3'd0;
      data_q    <= 8'h00;
      len_q     <= 2'd0;
      par_en_q  <= 1'b0;
      even_q    <= 1'b0;
      stick_q   <= 1'b0;
      par_acc_q <= 1'b0;
      par_err_q <= 1'b0;
      zero_q    <= 1'b0;
      fdata_q   <= 8'h00;
      we_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      rx_prev_q <= rx_prev_d;
      arm_q     <= arm_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      even_q    <= even_d;
      stick_q   <= stick_d;
      par_acc_q <= par_acc_d;
      par_err_q <= par_err_d;
      zero_q    <= zero_d;
      fdata_q   <= fdata_d;
      we_q      <= we_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  assign fifoWe        = we_q;
  assign fifoData      = fdata_q;
  assign parityError   = perr_q;
  assign frameError    = ferr_q;
  assign breakDetected = brk_q;
  assign overrunError  = ovr_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx. Each driven character pushes
// its expected report to a queue; a monitor pops and compares whenever the
// receiver raises a write or status pulse.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int TICK_DIV = 4;              // clocks per 16x tick
  localparam int BIT_CLKS = 16 * TICK_DIV;  // clocks per bit

  logic       clock = 1'b0;
  logic       reset;
  logic       baudRateX16tick;
  logic [6:0] controlReg;
  logic       uartRxLine;
  logic       fifoFull;
  logic       fifoWe;
  logic [7:0] fifoData;
  logic       parityError, frameError, breakDetected, overrunError, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       we, perr, ferr, brk, ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_rx dut (
    .clock           (clock),
    .reset           (reset),
    .baudRateX16tick (baudRateX16tick),
    .controlReg      (controlReg),
    .uartRxLine      (uartRxLine),
    .fifoFull        (fifoFull),
    .fifoWe          (fifoWe),
    .fifoData        (fifoData),
    .parityError     (parityError),
    .frameError      (frameError),
    .breakDetected   (breakDetected),
    .overrunError    (overrunError),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  initial begin
    int div;
    div = 0;
    baudRateX16tick = 1'b0;
    forever begin
      @(negedge clock);
      div = (div == TICK_DIV - 1) ? 0 : div + 1;
      baudRateX16tick = (div == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: any write or status pulse is one character report.
  always @(negedge clock) begin
    if (!reset && (fifoWe || parityError || frameError || breakDetected || overrunError)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_report",
              {27'd0, fifoWe, parityError, frameError, breakDetected, overrunError}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("fifo_we",  fifoWe,        mon_e.we);
        check("parity",   parityError,   mon_e.perr);
        check("frame",    frameError,    mon_e.ferr);
        check("break",    breakDetected, mon_e.brk);
        check("overrun",  overrunError,  mon_e.ovr);
        if (mon_e.we) check("fifo_data", fifoData, mon_e.data);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLKS) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Drives one character; cfg applies at the start, cfg_late after the start
  // bit (the receiver must keep the format it latched at start validation).
  task automatic frame(input logic [6:0] cfg, input logic [6:0] cfg_late,
                       input logic [7:0] d, input logic par_bit,
                       input logic stop_bit, input logic full);
    int   nbits;
    logic [7:0] m;
    logic exp_par;
    exp_t e;
    nbits   = 5 + int'(cfg[1:0]);
    m       = 8'h00;
    for (int i = 0; i < nbits; i++) m[i] = d[i];
    exp_par = cfg[5] ? ~cfg[4] : ~((^m) ^ cfg[4]);
    e.data  = m;
    e.we    = !full;
    e.ovr   = full;
    e.ferr  = !stop_bit;
    e.perr  = cfg[3] && (par_bit != exp_par);
    e.brk   = (m == 8'h00) && (!cfg[3] || !par_bit) && !stop_bit;
    exp_q.push_back(e);

    controlReg = cfg;
    fifoFull   = full;
    uartRxLine = 1'b0;
    wait_clks(BIT_CLKS);
    controlReg = cfg_late;
    for (int i = 0; i < nbits; i++) begin
      uartRxLine = d[i];
      wait_clks(BIT_CLKS);
    end
    if (cfg[3]) begin
      uartRxLine = par_bit;
      wait_clks(BIT_CLKS);
    end
    uartRxLine = stop_bit;
    wait_clks(BIT_CLKS);
    fifoFull   = 1'b0;
  endtask

  task automatic good_frame(input logic [6:0] cfg, input logic [7:0] d, input logic par_bit);
    frame(cfg, cfg, d, par_bit, 1'b1, 1'b0);
    wait_clks(BIT_CLKS / 2);
    drain("drain");
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    controlReg = 7'h03;
    uartRxLine = 1'b1;
    fifoFull   = 1'b0;
    wait_clks(4);
    check("rst_busy",  busy,   1'b0);
    check("rst_we",    fifoWe, 1'b0);
    check("rst_data",  fifoData, 8'h00);
    reset = 1'b0;
    wait_clks(BIT_CLKS);

    // 8N1 0x55
    good_frame(7'h03, 8'h55, 1'b0);
    // 7 bits odd parity, wrong parity bit
    good_frame(7'h0A, 8'h41, 1'b0);
    // 7 bits even parity, correct parity bit
    good_frame(7'h1A, 8'h41, 1'b0);
    // stick parity: expected 1 with [4]=0, expected 0 with [4]=1
    good_frame(7'h2B, 8'hC3, 1'b1);
    good_frame(7'h3B, 8'hC3, 1'b1);
    // 5 data bits, ignored bits [2] and [6] set
    good_frame(7'h44, 8'h15, 1'b0);

    // framing error, then recovery
    frame(7'h03, 7'h03, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("recover_busy", busy, 1'b1);
    drain("drain_frame");
    uartRxLine = 1'b1;
    wait_clks(BIT_CLKS);
    check("recover_idle", busy, 1'b0);

    // break: line low for 30 bit times gives a single report
    exp_q.push_back('{data: 8'h00, we: 1'b1, perr: 1'b0, ferr: 1'b1, brk: 1'b1, ovr: 1'b0});
    controlReg = 7'h03;
    uartRxLine = 1'b0;
    wait_clks(30 * BIT_CLKS);
    drain("drain_break");
    check("break_busy", busy, 1'b1);
    uartRxLine = 1'b1;
    wait_clks(BIT_CLKS);
    good_frame(7'h03, 8'h55, 1'b0);

    // overrun
    frame(7'h03, 7'h03, 8'h33, 1'b0, 1'b1, 1'b1);
    wait_clks(BIT_CLKS / 2);
    drain("drain_overrun");

    // format change mid-frame is ignored until the next character
    frame(7'h03, 7'h00, 8'hA3, 1'b0, 1'b1, 1'b0);
    wait_clks(BIT_CLKS / 2);
    drain("drain_cfg");

    // glitch of 4 tick periods: false start, no report
    uartRxLine = 1'b0;
    wait_clks(3 * TICK_DIV);
    check("glitch_busy", busy, 1'b1);
    wait_clks(TICK_DIV);
    uartRxLine = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_idle", busy, 1'b0);

    // reset during the third data bit
    controlReg = 7'h03;
    uartRxLine = 1'b0;
    wait_clks(BIT_CLKS);
    uartRxLine = 1'b1;
    wait_clks(BIT_CLKS);
    uartRxLine = 1'b0;
    wait_clks(BIT_CLKS);
    uartRxLine = 1'b1;
    wait_clks(BIT_CLKS / 3);
    reset = 1'b1;
    wait_clks(3);
    check("midrst_busy", busy, 1'b0);
    check("midrst_we",   fifoWe, 1'b0);
    check("midrst_data", fifoData, 8'h00);
    reset = 1'b0;
    wait_clks(3 * BIT_CLKS);
    check("midrst_idle", busy, 1'b0);
    good_frame(7'h03, 8'h7E, 1'b0);

    // low line across reset release must not start a frame
    reset      = 1'b1;
    uartRxLine = 1'b0;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);
    check("lowrst_busy", busy, 1'b0);
    uartRxLine = 1'b1;
    wait_clks(BIT_CLKS);
    good_frame(7'h03, 8'h96, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
